// File: rtl/jtag_emu_shifter_if.sv
// rtl/jtag_emu_shifter_if.sv - command/response bundle for the JTAG emulation shifter
//
// Purpose: groups the command and response handshakes of jtag_emu_shifter.
// Signals:
//   cmd_valid/cmd_ready   command handshake (accepted when both high)
//   cmd_trst              1 = TAP reset pulse, 0 = shift
//   cmd_len               shift length in bits (values above 32 clamp to 32)
//   cmd_tms/cmd_tdi       per-bit TMS/TDI values, bit i used in TCK cycle i
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              captured TDO bits
// Modports: master = command issuer / response consumer, slave = shifter.

interface jtag_emu_shifter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_trst;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_trst, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_trst, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_emu_shifter.sv
// rtl/jtag_emu_shifter.sv - JTAG bit shifter driving a core TAP from single commands
//
// Purpose: accepts one command at a time; either shifts up to 32 TMS/TDI bits
// out on a divided TCK while capturing TDO, or pulses TRST. Returns one
// response per command.
// Parameters:
//   CLK_DIV  TCK half-period in clk cycles (1..255)
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   bus      jtag_emu_shifter_if.slave (command in, response out)
//   tck_o, tms_o, tdi_o, trstn_o   JTAG pins toward the core TAP
//   tdo_i    TDO from the core TAP
//   busy_o   high whenever not IDLE

module jtag_emu_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  jtag_emu_shifter_if.slave  bus,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  output logic               trstn_o,
  input  logic               tdo_i,
  output logic               busy_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_TRST = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

  logic [2:0]  state;
  logic [7:0]  half_cnt;
  logic [5:0]  bit_idx;
  logic [5:0]  bit_len;
  logic [31:0] tms_q;
  logic [31:0] tdi_q;
  logic [31:0] rsp_q;
  logic [5:0]  eff_len;

  always_comb begin
    eff_len = (bus.cmd_len > 6'd32) ? 6'd32 : bus.cmd_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      half_cnt <= 8'd0;
      bit_idx  <= 6'd0;
      bit_len  <= 6'd0;
      tms_q    <= 32'd0;
      tdi_q    <= 32'd0;
      rsp_q    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready is high in IDLE, so cmd_valid alone completes the handshake
          if (bus.cmd_valid) begin
            half_cnt <= HALF_RELOAD;
            bit_idx  <= 6'd0;
            rsp_q    <= 32'd0;
            tms_q    <= bus.cmd_tms;
            tdi_q    <= bus.cmd_tdi;
            bit_len  <= eff_len;
            if (bus.cmd_trst) begin
              state <= ST_TRST;
            end else if (eff_len == 6'd0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_LOW;
            end
          end
        end

        ST_LOW: begin
          if (half_cnt == 8'd0) begin
            // this edge raises tck_o, so it is also the TDO capture edge
            state                <= ST_HIGH;
            half_cnt             <= HALF_RELOAD;
            rsp_q[bit_idx[4:0]]  <= tdo_i;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        ST_HIGH: begin
          if (half_cnt == 8'd0) begin
            half_cnt <= HALF_RELOAD;
            if ((bit_idx + 6'd1) < bit_len) begin
              bit_idx <= bit_idx + 6'd1;
              state   <= ST_LOW;
            end else begin
              state <= ST_RESP;
            end
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        ST_TRST: begin
          // two half-periods; bit_idx serves as the phase so the 8-bit
          // counter never has to hold 2*CLK_DIV
          if (half_cnt == 8'd0) begin
            half_cnt <= HALF_RELOAD;
            if (bit_idx == 6'd0) begin
              bit_idx <= 6'd1;
            end else begin
              state <= ST_RESP;
            end
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            state    <= ST_IDLE;
            half_cnt <= HALF_RELOAD;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic shifting;

  always_comb begin
    shifting      = (state == ST_LOW) || (state == ST_HIGH);
    tck_o         = (state == ST_HIGH);
    // TMS parks at 1 outside a shift (TRST also drives 1)
    tms_o         = shifting ? tms_q[bit_idx[4:0]] : 1'b1;
    tdi_o         = shifting ? tdi_q[bit_idx[4:0]] : 1'b0;
    trstn_o       = (state != ST_TRST);
    busy_o        = (state != ST_IDLE);
    bus.cmd_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_RESP);
    bus.rsp_data  = rsp_q;
  end

endmodule

// File: tb/tb_jtag_emu_shifter.sv
// tb/tb_jtag_emu_shifter.sv - self-checking bench for jtag_emu_shifter at CLK_DIV 1, 2 and 4

module tb_jtag_emu_shifter;

  logic clk;
  logic rst;

  logic        cmd_valid [3];
  logic        cmd_trst  [3];
  logic [5:0]  cmd_len   [3];
  logic [31:0] cmd_tms   [3];
  logic [31:0] cmd_tdi   [3];
  logic        rsp_ready [3];
  logic        cmd_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_data  [3];
  logic        tck       [3];
  logic        tms       [3];
  logic        tdi       [3];
  logic        trstn     [3];
  logic        busy      [3];
  logic        tdo       [3];
  logic [31:0] tdo_pat   [3];
  logic [5:0]  edge_cnt  [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    jtag_emu_shifter_if bus ();
    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_trst  = cmd_trst[g];
    assign bus.cmd_len   = cmd_len[g];
    assign bus.cmd_tms   = cmd_tms[g];
    assign bus.cmd_tdi   = cmd_tdi[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign cmd_ready[g]  = bus.cmd_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_data[g]   = bus.rsp_data;
    // the core TAP model returns pattern bit k before the k-th TCK rise
    assign tdo[g]        = tdo_pat[g][edge_cnt[g][4:0]];

    jtag_emu_shifter #(.CLK_DIV(DIV)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .tck_o   (tck[g]),
      .tms_o   (tms[g]),
      .tdi_o   (tdi[g]),
      .trstn_o (trstn[g]),
      .tdo_i   (tdo[g]),
      .busy_o  (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic check_reset_vals(input int d);
    check("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("rst_rsp_data",  rsp_data[d],       32'd0);
    check("rst_busy",      32'(busy[d]),      32'd0);
    check("rst_tck",       32'(tck[d]),       32'd0);
    check("rst_tms",       32'(tms[d]),       32'd1);
    check("rst_tdi",       32'(tdi[d]),       32'd0);
    check("rst_trstn",     32'(trstn[d]),     32'd1);
  endtask

  // One complete command with its response. Expectations come from the
  // command semantics: L clamped to 32, 2*DIV cycles per bit, TDO captured
  // per rising TCK edge, TRST = 2*DIV cycles of trstn low.
  task automatic run_cmd(input int d, input bit trst, input logic [5:0] len,
                         input logic [31:0] tms_v, input logic [31:0] tdi_v,
                         input logic [31:0] pat, input int hold);
    int          div;
    int          leff;
    int          cyc;
    int          rises;
    int          trst_low;
    logic        prev_tck;
    logic [31:0] mask;
    logic [31:0] exp_data;
    logic [31:0] held;

    div      = div_of(d);
    leff     = trst ? 0 : ((len > 6'd32) ? 32 : int'(len));
    mask     = (leff >= 32) ? 32'hFFFF_FFFF : ((32'd1 << leff) - 32'd1);
    exp_data = trst ? 32'd0 : (pat & mask);

    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_trst[d]  = trst;
    cmd_len[d]   = len;
    cmd_tms[d]   = tms_v;
    cmd_tdi[d]   = tdi_v;
    tdo_pat[d]   = pat;
    edge_cnt[d]  = 6'd0;
    @(negedge clk);
    // fields change after acceptance and must have no effect
    cmd_valid[d] = 1'b0;
    cmd_trst[d]  = 1'($urandom);
    cmd_len[d]   = 6'($urandom);
    cmd_tms[d]   = $urandom;
    cmd_tdi[d]   = $urandom;

    cyc      = 1;
    rises    = 0;
    trst_low = 0;
    prev_tck = 1'b0;
    while (!rsp_valid[d] && cyc < 3000) begin
      if (tck[d] && !prev_tck) begin
        if (rises < 32) begin
          check("tms_at_rise", 32'(tms[d]), 32'(tms_v[rises]));
          check("tdi_at_rise", 32'(tdi[d]), 32'(tdi_v[rises]));
        end
        rises++;
        edge_cnt[d] = 6'(rises);
      end
      if (!trstn[d]) begin
        trst_low++;
        check("trst_tms", 32'(tms[d]), 32'd1);
        check("trst_tdi", 32'(tdi[d]), 32'd0);
      end
      check("busy_in_cmd", 32'(busy[d]), 32'd1);
      check("ready_in_cmd", 32'(cmd_ready[d]), 32'd0);
      prev_tck     = tck[d];
      rsp_ready[d] = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    rsp_ready[d] = 1'b0;

    check("rsp_timeout", 32'(rsp_valid[d]), 32'd1);
    check("rsp_latency", 32'(cyc), 32'(1 + 2 * div * leff + (trst ? 2 * div : 0)));
    check("tck_rises", 32'(rises), 32'(leff));
    check("trst_cycles", 32'(trst_low), trst ? 32'(2 * div) : 32'd0);
    check("rsp_data", rsp_data[d], exp_data);
    check("resp_tck", 32'(tck[d]), 32'd0);
    check("resp_tms", 32'(tms[d]), 32'd1);
    check("resp_tdi", 32'(tdi[d]), 32'd0);
    check("resp_trstn", 32'(trstn[d]), 32'd1);

    held = rsp_data[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_data", rsp_data[d], held);
      check("hold_ready", 32'(cmd_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    check("post_busy", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int d = 0; d < 3; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_trst[d]  = 1'b0;
      cmd_len[d]   = 6'd0;
      cmd_tms[d]   = 32'd0;
      cmd_tdi[d]   = 32'd0;
      rsp_ready[d] = 1'b0;
      tdo_pat[d]   = 32'd0;
      edge_cnt[d]  = 6'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset_vals(d);
    rst = 1'b0;

    // directed: DIV=2 len 8 loopback, DIV=1 TMS all ones, clamp, zero length
    run_cmd(1, 1'b0, 6'd8,  32'h0000_0000, 32'h0000_00A5, 32'h0000_00A5, 0);
    run_cmd(0, 1'b0, 6'd5,  32'h0000_001F, 32'h0000_0000, 32'h0000_0000, 1);
    run_cmd(2, 1'b0, 6'd40, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 0);
    run_cmd(0, 1'b0, 6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_cmd(2, 1'b1, 6'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_cmd(1, 1'b0, 6'd32, $urandom, $urandom, $urandom, 10);

    // reset in the middle of the third bit of a len=16 shift
    @(negedge clk);
    cmd_valid[1] = 1'b1;
    cmd_trst[1]  = 1'b0;
    cmd_len[1]   = 6'd16;
    cmd_tms[1]   = $urandom;
    cmd_tdi[1]   = $urandom;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    cyc = 0;
    // third bit begins 2 bits * 4 cycles after T+1
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_shift_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals(1);
    run_cmd(1, 1'b0, 6'd4, $urandom, $urandom, $urandom, 0);

    // randomized commands across all three dividers
    for (int n = 0; n < 40; n++) begin
      run_cmd(int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
              6'($urandom_range(0, 63)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_emu_shifter.md
JTAG_EMU_SHIFTER -- requirements
Module: jtag_emu_shifter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: TCK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_trst  input  1  1 = TAP reset pulse command; 0 = shift command.
REQ-007 SHALL have port cmd_len  input  6  shift length in bits, 0..63.
REQ-008 SHALL have port cmd_tms  input  32  TMS value per bit; bit i is driven during TCK cycle i.
REQ-009 SHALL have port cmd_tdi  input  32  TDI value per bit; bit i is driven during TCK cycle i.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_data  output  32  captured TDO bits.
REQ-013 SHALL have ports tck_o, tms_o, tdi_o, trstn_o  output  1 each  JTAG pins toward the core TAP.
REQ-014 SHALL have port tdo_i  input  1  TDO from the core TAP.
REQ-015 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, LOW, HIGH, TRST and RESP.
REQ-017 cmd_ready SHALL be high only in IDLE; commands are never buffered.
REQ-018 The command fields SHALL be latched on the acceptance cycle T; later changes to the inputs SHALL be ignored.
REQ-019 Shift command with effective length L > 0: IDLE SHALL go to LOW at T+1, with bit index 0 and the rsp_data shift register cleared.
REQ-020 LOW: tck_o=0, tms_o=tms[i], tdi_o=tdi[i]; after CLK_DIV cycles the state SHALL go to HIGH.
REQ-021 HIGH: tck_o=1; tms_o and tdi_o SHALL be held stable.
REQ-022 tdo_i SHALL be captured into rsp_data[i] on the clk edge at which tck_o transitions 0->1.
REQ-023 After CLK_DIV cycles in HIGH, the block SHALL go to LOW with i+1 if i+1<L, else to RESP.
REQ-024 Each bit SHALL take exactly 2*CLK_DIV cycles; rsp_valid SHALL rise at T+1+2*CLK_DIV*L.
REQ-025 Length clamp: cmd_len >32 SHALL be treated as L=32.
REQ-026 cmd_len=0 SHALL go to RESP at T+1 with rsp_data=0 and no TCK edge.
REQ-027 rsp_data bits [31:L] SHALL be 0.
REQ-028 TRST command: TRST state for 2*CLK_DIV cycles with trstn_o=0, tck_o=0 and tms_o=1, then RESP with rsp_data=0; cmd_len, cmd_tms and cmd_tdi SHALL be ignored.
REQ-029 RESP: rsp_valid=1 and rsp_data SHALL be held stable until rsp_ready is sampled high; then the state SHALL return to IDLE on the next cycle.
REQ-030 cmd_ready SHALL rise in the cycle after the rsp handshake; the next command is therefore accepted no earlier than the cycle following that.
REQ-031 rsp_ready high outside RESP SHALL be ignored.
REQ-032 tck_o SHALL be low in IDLE, TRST and RESP.
REQ-033 tms_o SHALL be 1 in IDLE and RESP, so the TAP is parked in its current stable state.
REQ-034 tdi_o SHALL be 0 in IDLE, TRST and RESP.
REQ-035 The half-period counter SHALL be 8 bits and reload to CLK_DIV-1 on every state entry.
REQ-036 The bit index SHALL be 6 bits; no counter shall wrap in legal operation.

Reset
REQ-037 rst high at any clock edge SHALL force IDLE on that edge, including mid-shift, mid-TRST and mid-RESP.
REQ-038 Reset values SHALL be: cmd_ready=1, rsp_valid=0, rsp_data=0, busy_o=0, tck_o=0, tms_o=1, tdi_o=0, trstn_o=1, counters=0.
REQ-039 A command or response pending at reset SHALL be discarded without any handshake.

Verification
REQ-040 CLK_DIV=2, shift with len=8, tms=0x00, tdi=0xA5, tdo_i following tdi_o -> 8 tck pulses of 4 cycles each; rsp_valid at T+33; rsp_data=0x000000A5.
REQ-041 CLK_DIV=1, len=5, tms=0x1F -> tms_o=1 on all 5 rising edges of tck_o; rsp_valid at T+11; then tck_o=0 and tms_o=1.
REQ-042 len=40, tdo_i=1 constant -> exactly 32 tck pulses; rsp_data=0xFFFFFFFF. Separately, len=0 -> rsp_valid at T+1 with rsp_data=0 and no tck edge.
REQ-043 TRST command with CLK_DIV=4 -> trstn_o low for exactly 8 cycles, no tck edge, rsp_data=0.
REQ-044 rsp_ready held low for 10 cycles in RESP -> rsp_valid and rsp_data stay stable; cmd_ready stays 0 until the cycle after the handshake.
REQ-045 rst asserted in the third bit of a len=16 shift -> all outputs equal the REQ-038 reset values at the next edge; a new len=4 command then completes normally.
